// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU data-memory responder: FSM encoding,
// bus widths and the latency counter width.
package mem_if_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_DLY = 3'd1,
    ACCEPT  = 3'd2,
    RD_DLY  = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/strb_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port
// (one cycle of read latency; the read register holds its value between reads).
module strb_ram
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STRB_W-1:0]     we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset so its contents survive rst and it maps onto
  // block RAM; only the read register below is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_W; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data interface: one transaction at a time,
// with programmable request-acceptance and read-response latencies.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int REQ_DELAY  = 2,
  parameter int RESP_DELAY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       Address,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] Write_data,
  input  logic [STRB_W-1:0] Write_strb,
  input  logic              MemRead,
  output logic              Mem_Req_Ready,
  output logic [DATA_W-1:0] Read_data,
  output logic              Read_data_Valid,
  input  logic              Read_data_Ready
);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0]   rd_idx, rd_idx_nxt;
  logic [ADDR_WIDTH-1:0]   addr_idx, ram_addr;
  logic [STRB_W-1:0]       ram_we;
  logic                    ram_re;

  assign addr_idx = Address[ADDR_WIDTH+1:2];

  // Byte offset and bits above the RAM index are ignored, so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_idx <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rd_idx <= rd_idx_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rd_idx_nxt = rd_idx;
    ram_we     = '0;
    ram_re     = 1'b0;
    unique case (state)
      IDLE: begin
        if (MemRead || MemWrite) begin
          if (REQ_DELAY == 0) begin
            state_nxt = ACCEPT;
          end else begin
            cnt_nxt   = CNT_W'(REQ_DELAY);
            state_nxt = REQ_DLY;
          end
        end
      end
      REQ_DLY: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_nxt = ACCEPT;
      end
      ACCEPT: begin
        if (MemWrite) begin
          ram_we    = Write_strb;
          state_nxt = IDLE;
        end else if (MemRead) begin
          rd_idx_nxt = addr_idx;
          if (RESP_DELAY == 0) begin
            ram_re    = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CNT_W'(RESP_DELAY);
            state_nxt = RD_DLY;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RD_DLY: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          ram_re    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (Read_data_Ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // During RD_DLY the live Address may already belong to the next request.
  assign ram_addr = (state == RD_DLY) ? rd_idx : addr_idx;

  assign Mem_Req_Ready   = (state == ACCEPT);
  assign Read_data_Valid = (state == RESP);

  strb_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (Write_data),
    .rdata (Read_data)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with default latencies
// (2/3) and one with zero latencies, sharing a stimulus bus selected by sel.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Address = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] Write_data = '0;
  logic [3:0]  Write_strb = '0;
  logic        MemRead = 1'b0;
  logic        Read_data_Ready = 1'b0;
  logic        sel = 1'b0;

  logic        rdy0, rdy1, vld0, vld1;
  logic [31:0] rd0, rd1;
  logic        rdy, vld;
  logic [31:0] rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(12), .REQ_DELAY(2), .RESP_DELAY(3)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .Address         (Address),
    .MemWrite        (MemWrite & ~sel),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .MemRead         (MemRead & ~sel),
    .Mem_Req_Ready   (rdy0),
    .Read_data       (rd0),
    .Read_data_Valid (vld0),
    .Read_data_Ready (Read_data_Ready & ~sel)
  );

  data_mem_responder #(.ADDR_WIDTH(12), .REQ_DELAY(0), .RESP_DELAY(0)) u_dut_zero (
    .clk             (clk),
    .rst             (rst),
    .Address         (Address),
    .MemWrite        (MemWrite & sel),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .MemRead         (MemRead & sel),
    .Mem_Req_Ready   (rdy1),
    .Read_data       (rd1),
    .Read_data_Valid (vld1),
    .Read_data_Ready (Read_data_Ready & sel)
  );

  assign rdy   = sel ? rdy1 : rdy0;
  assign vld   = sel ? vld1 : vld0;
  assign rdata = sel ? rd1  : rd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a request and waits (bounded) for Mem_Req_Ready; inputs stay held.
  task automatic issue(input logic [31:0] a, input logic w, input logic r,
                       input logic [31:0] d, input logic [3:0] s,
                       input int exp_lat, input string tag);
    int lat;
    Address = a; MemWrite = w; MemRead = r; Write_data = d; Write_strb = s;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rdy) begin
        lat = k;
        break;
      end
    end
    check({tag, " req_latency"}, lat, exp_lat);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int exp_lat, input string tag);
    issue(a, 1'b1, 1'b0, d, s, exp_lat, tag);
    @(negedge clk);
    MemWrite = 1'b0;
    check({tag, " ready_drop"}, {31'd0, rdy}, 32'd0);
  endtask

  // Waits for Read_data_Valid after the ACCEPT cycle; inputs drop after one edge.
  task automatic wait_valid(input int exp_lat, input string tag);
    int lat;
    lat = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 1) begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
      end
      if (vld) begin
        lat = j;
        break;
      end
    end
    check({tag, " resp_latency"}, lat, exp_lat);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                         input int req_lat, input int resp_lat, input string tag);
    issue(a, 1'b0, 1'b1, 32'h0, 4'h0, req_lat, tag);
    wait_valid(resp_lat, tag);
    check({tag, " data"}, rdata, exp_data);
    Read_data_Ready = 1'b1;
    @(negedge clk);
    Read_data_Ready = 1'b0;
    check({tag, " valid_drop"}, {31'd0, vld}, 32'd0);
    check({tag, " data_hold"}, rdata, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;

    // Asynchronous reset asserted in the middle of a cycle.
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst ready", {31'd0, rdy0}, 32'd0);
    check("rst valid", {31'd0, vld0}, 32'd0);
    check("rst data", rd0, 32'd0);
    check("rst zero valid", {31'd0, vld1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle ready", {31'd0, rdy0}, 32'd0);
    check("idle valid", {31'd0, vld0}, 32'd0);
    check("idle data", rd0, 32'd0);

    // Full write then read with default latencies.
    do_write(32'h100, 32'hDEADBEEF, 4'hF, 3, "wr100");
    do_read(32'h100, 32'hDEADBEEF, 3, 4, "rd100");

    // Byte strobes, then a read through an aliased (wrapped) address.
    do_write(32'h20, 32'h11223344, 4'hF, 3, "wr20a");
    do_write(32'h20, 32'hAABBCCDD, 4'b0101, 3, "wr20b");
    do_read(32'h20 + (32'd4 << 12), 32'h11BB33DD, 3, 4, "rdwrap");

    // Response backpressure with a write pending behind it.
    issue(32'h100, 1'b0, 1'b1, 32'h0, 4'h0, 3, "bp");
    wait_valid(4, "bp");
    Address = 32'h40; MemWrite = 1'b1; Write_data = 32'hCAFEF00D; Write_strb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp valid_held", {31'd0, vld}, 32'd1);
      check("bp data_held", rdata, 32'hDEADBEEF);
      check("bp no_ready", {31'd0, rdy}, 32'd0);
    end
    Read_data_Ready = 1'b1;
    @(negedge clk);
    Read_data_Ready = 1'b0;
    check("bp valid_drop", {31'd0, vld}, 32'd0);
    // The held write is sampled in IDLE from here on.
    issue(32'h40, 1'b1, 1'b0, 32'hCAFEF00D, 4'hF, 3, "bpwr");
    @(negedge clk);
    MemWrite = 1'b0;
    do_read(32'h40, 32'hCAFEF00D, 3, 4, "rd40");

    // Reset during RD_DLY discards the read.
    issue(32'h100, 1'b0, 1'b1, 32'h0, 4'h0, 3, "rstrd");
    @(negedge clk);
    MemRead = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstrd valid", {31'd0, vld}, 32'd0);
    check("rstrd data", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= vld;
    end
    check("rstrd no_valid", {31'd0, seen}, 32'd0);
    do_read(32'h20, 32'h11BB33DD, 3, 4, "rdkeep");

    // Zero-latency instance: simultaneous read+write acts as a write only.
    sel = 1'b1;
    issue(32'h7C, 1'b1, 1'b1, 32'h0BADC0DE, 4'hF, 1, "zboth");
    @(negedge clk);
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= vld;
    end
    check("zboth no_valid", {31'd0, seen}, 32'd0);
    do_read(32'h7C, 32'h0BADC0DE, 1, 1, "zrd");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data memory interface: the memory request channel (Address/MemWrite/Write_data/Write_strb/MemRead/Mem_Req_Ready) and the read data response channel (Read_data/Read_data_Valid/Read_data_Ready).
- Holds a word-addressed, byte-strobed RAM.
- Inserts configurable request-acceptance and read-response latencies so pipeline stall and handshake paths are exercised in simulation and on FPGA.
- Serves one transaction at a time; no outstanding-request queue.

Parameters:
- ADDR_WIDTH, 12, word-address bits; RAM depth is 2**ADDR_WIDTH words of 32 bits.
- REQ_DELAY, 2, idle cycles between seeing a request and asserting Mem_Req_Ready (0..15).
- RESP_DELAY, 3, cycles between read acceptance and Read_data_Valid (0..15).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low: rst=0 resets immediately.
- Address  in  32  byte address; bits [1:0] ignored; bits [ADDR_WIDTH+1:2] index the RAM; upper bits ignored, so addresses wrap.
- MemWrite  in  1  write request.
- Write_data  in  32  write data.
- Write_strb  in  4  byte enables; bit i enables bits [8i+7:8i].
- MemRead  in  1  read request.
- Mem_Req_Ready  out  1  request accepted this cycle.
- Read_data  out  32  read response data.
- Read_data_Valid  out  1  response valid.
- Read_data_Ready  in  1  CPU accepts the response.

Behaviour:
- States: IDLE, REQ_DLY, ACCEPT, RD_DLY, RESP. Outputs are Moore outputs, decoded from registered state.
- Reset (rst=0, asynchronous):
  - state=IDLE, Mem_Req_Ready=0, Read_data_Valid=0, Read_data=0, delay counter=0.
  - RAM contents are preserved.
  - A reset mid-transaction discards the pending write or read; no response is issued after release.
- IDLE: Mem_Req_Ready=0. When MemRead|MemWrite is sampled high:
  - REQ_DELAY=0: go to ACCEPT.
  - otherwise: load cnt=REQ_DELAY and go to REQ_DLY.
- REQ_DLY: cnt decrements each cycle; on the edge where cnt==1, go to ACCEPT.
  - Request latency is therefore REQ_DELAY+1 cycles from first sampling to the Mem_Req_Ready cycle.
- ACCEPT: Mem_Req_Ready=1 for exactly one cycle; the handshake completes in this cycle. The CPU holds its request until it sees ready.
  - MemWrite=1: at the clock edge, write the enabled bytes of Write_data to RAM[Address word index]; go to IDLE. Write_strb=0 writes nothing and still completes.
  - MemRead=1 and MemWrite=0: capture the word index.
    - RESP_DELAY=0: load Read_data from RAM and go to RESP.
    - otherwise: load cnt=RESP_DELAY and go to RD_DLY.
  - MemRead and MemWrite both 1: the write takes priority and no read response is issued.
  - Neither asserted (protocol violation): go to IDLE with no side effects.
- RD_DLY: cnt decrements; on the edge where cnt==1, load Read_data from RAM at the captured index and go to RESP.
- RESP: Read_data_Valid=1 and Read_data is stable.
  - When Read_data_Ready=1, the handshake completes; go to IDLE, and Read_data_Valid drops the next cycle.
  - Read_data keeps its last value after the response.
  - Requests seen in RESP are ignored until IDLE; Mem_Req_Ready stays 0.
- Minimum read turnaround, request to Valid: REQ_DELAY+RESP_DELAY+2 cycles.
- Ordering: a write is committed at its ACCEPT edge, so any later read returns the new data. Back-to-back requests each re-enter IDLE, giving a 1-cycle bubble.
- Counter width is 4 bits and never underflows.

Decomposition:
- Shared package (mem_if_pkg) holds:
  - state encoding constants for IDLE, REQ_DLY, ACCEPT, RD_DLY, RESP;
  - DATA_W=32, STRB_W=4;
  - the delay counter width.
- One sub-module, strb_ram:
  - synchronous single-port 32-bit RAM with 4-bit byte write enable;
  - read data registered, 1-cycle latency;
  - read enable is asserted in the cycle before RESP is entered.

Test Plan:
- Reset then idle: drive rst=0 mid-cycle -> Mem_Req_Ready=0, Read_data_Valid=0 and Read_data=0 asynchronously; they remain 0 with no requests after release.
- Full write/read (REQ_DELAY=2, RESP_DELAY=3): write 0xDEADBEEF to 0x100 with strb=4'hF, then read 0x100 -> Mem_Req_Ready pulses on the 3rd cycle after the request appears; Read_data_Valid rises 4 cycles after the read ACCEPT cycle with Read_data=0xDEADBEEF.
- Byte strobes and wrap: write 0x11223344 to 0x20 with strb=4'hF, write 0xAABBCCDD to 0x20 with strb=4'b0101, then read address 0x20+(4<<ADDR_WIDTH) -> 0x11BB33DD.
- Response backpressure: hold Read_data_Ready=0 for 5 cycles -> Read_data_Valid and Read_data stay stable and a concurrent MemWrite gets no Mem_Req_Ready; raising Ready -> Valid=0 the next cycle and the write is then served.
- Reset mid-read: assert rst during RD_DLY -> no Read_data_Valid after release; a subsequent read of a previously written address returns the preserved data.
- Zero delays (REQ_DELAY=0, RESP_DELAY=0) with MemRead and MemWrite both high -> the write commits, no read response; a following read returns the written data in minimum turnaround (2 cycles).
